// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM states,
// owner encoding, the cleared-data value and the arbitration decision.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam logic [31:0] RST_DATA = 32'h0000_0000;

  // Data wins a tie unless its streak has used up the fetch path's patience.
  function automatic logic pick_data(input logic if_req, input logic d_req,
                                     input logic streak_full);
    return d_req && (!if_req || !streak_full);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Watchdog counter for BUSY transactions: counts enabled cycles and flags
// expiry when the count equals TIMEOUT (never expires when TIMEOUT is 0).
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] cnt_r;
  logic             match_s;

  // Cycle counter, cleared between transactions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign match_s = (cnt_r == CNT_W'(TIMEOUT));
  assign expire  = (TIMEOUT != 0) && match_s;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the single memory port between instruction fetch and load/store,
// one transaction at a time, data-priority with a bounded streak.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT         = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        bus_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_wrt,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  state_t      state_r;
  owner_t      owner_r;
  logic [3:0]  streak_r;
  logic        streak_full_s;
  logic        grant_d_s;
  logic        wd_clr_s;
  logic        wd_en_s;
  logic        wd_expire_s;

  // Arbitration decision and watchdog controls from the current state.
  always_comb begin
    streak_full_s = (streak_r == 4'(MAX_DATA_STREAK));
    grant_d_s     = pick_data(if_req, d_req, streak_full_s);
    wd_clr_s      = (state_r == DONE);
    wd_en_s       = (state_r == BUSY) && !mem_ready && !wd_expire_s;
  end

  bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wd_clr_s),
    .en     (wd_en_s),
    .expire (wd_expire_s)
  );

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      owner_r   <= OWN_IF;
      streak_r  <= 4'd0;
      if_rdata  <= RST_DATA;
      d_rdata   <= RST_DATA;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      bus_err   <= 1'b0;
      mem_addr  <= RST_DATA;
      mem_wdata <= RST_DATA;
      mem_read  <= 1'b0;
      mem_wrt   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (if_req || d_req) begin
            if (grant_d_s) begin
              owner_r   <= OWN_D;
              mem_addr  <= d_addr;
              mem_wdata <= d_wr ? d_wdata : RST_DATA;
              mem_read  <= !d_wr;
              mem_wrt   <= d_wr;
              if (!if_req) begin
                streak_r <= 4'd0;
              end else if (streak_full_s) begin
                streak_r <= streak_r;
              end else begin
                streak_r <= streak_r + 4'd1;
              end
            end else begin
              owner_r   <= OWN_IF;
              mem_addr  <= if_addr;
              mem_wdata <= RST_DATA;
              mem_read  <= 1'b1;
              mem_wrt   <= 1'b0;
              streak_r  <= 4'd0;
            end
            state_r <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (mem_ready || wd_expire_s) begin
            // Ready on the expiring cycle still counts as a success.
            if (owner_r == OWN_IF) begin
              if_rdata <= mem_ready ? mem_rdata : RST_DATA;
            end else begin
              d_rdata  <= (mem_ready && !mem_wrt) ? mem_rdata : RST_DATA;
            end
            if_ack   <= (owner_r == OWN_IF);
            d_ack    <= (owner_r == OWN_D);
            bus_err  <= !mem_ready;
            mem_read <= 1'b0;
            mem_wrt  <= 1'b0;
            state_r  <= DONE;
          end else begin
            state_r <= BUSY;
          end
        end
        DONE: begin
          if_ack  <= 1'b0;
          d_ack   <= 1'b0;
          bus_err <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          if_ack   <= 1'b0;
          d_ack    <= 1'b0;
          bus_err  <= 1'b0;
          mem_read <= 1'b0;
          mem_wrt  <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (MAX_DATA_STREAK=4, TIMEOUT=15).
module tb_mem_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        bus_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_wrt;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int n_checks = 0;
  int n_errors = 0;

  mem_bus_arbiter #(
    .MAX_DATA_STREAK (4),
    .TIMEOUT         (15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .bus_err   (bus_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_wrt   (mem_wrt),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs set and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] grant_addr [10];
  logic [31:0] exp_grant;
  int          n_grants;

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_wr = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b0;
    step(); step();
    check_eq("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check_eq("rst_mem_wrt",  {31'd0, mem_wrt}, 32'd0);
    check_eq("rst_acks",     {29'd0, if_ack, d_ack, bus_err}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    rst_n = 1'b1;
    step();

    // Single fetch, ready in cycle 1.
    if_req = 1'b1; if_addr = 32'h10; mem_rdata = 32'h8C22_0004;
    step();
    check_eq("fetch_mem_read", {31'd0, mem_read}, 32'd1);
    check_eq("fetch_mem_addr", mem_addr, 32'h10);
    check_eq("fetch_mem_wrt",  {31'd0, mem_wrt}, 32'd0);
    mem_ready = 1'b1;
    step();
    check_eq("fetch_ack",   {31'd0, if_ack}, 32'd1);
    check_eq("fetch_rdata", if_rdata, 32'h8C22_0004);
    check_eq("fetch_err",   {31'd0, bus_err}, 32'd0);
    if_req = 1'b0; mem_ready = 1'b0;
    step();
    check_eq("fetch_ack_pulse", {31'd0, if_ack}, 32'd0);
    check_eq("fetch_rdata_hold", if_rdata, 32'h8C22_0004);

    // Contention: both held, ready immediate; expect D,D,D,D,IF,D,D,D,D,IF.
    if_req = 1'b1; if_addr = 32'h100; d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h200;
    mem_rdata = 32'hCAFE_0001; mem_ready = 1'b1;
    n_grants = 0;
    for (int c = 0; c < 40 && n_grants < 10; c++) begin
      step();
      if (mem_read) begin
        grant_addr[n_grants] = mem_addr;
        n_grants++;
        if (n_grants == 10) begin
          if_req = 1'b0; d_req = 1'b0;
        end
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    check_eq("cont_grant_count", n_grants, 32'd10);
    for (int g = 0; g < n_grants; g++) begin
      exp_grant = (g == 4 || g == 9) ? 32'h100 : 32'h200;
      check_eq($sformatf("cont_grant%0d", g), grant_addr[g], exp_grant);
    end
    step(); step();
    mem_ready = 1'b0;
    check_eq("cont_d_rdata", d_rdata, 32'hCAFE_0001);
    step();

    // Store with ready in cycle 4.
    d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234; mem_rdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 4; c++) begin
      step();
      check_eq($sformatf("st_wrt_c%0d", c), {31'd0, mem_wrt}, 32'd1);
      check_eq($sformatf("st_rd_c%0d", c),  {31'd0, mem_read}, 32'd0);
      check_eq($sformatf("st_ack_c%0d", c), {31'd0, d_ack}, 32'd0);
      if (c == 1) begin
        check_eq("st_addr",  mem_addr, 32'h40);
        check_eq("st_wdata", mem_wdata, 32'h1234);
      end
      if (c == 4) mem_ready = 1'b1;
    end
    step();
    check_eq("st_ack",   {31'd0, d_ack}, 32'd1);
    check_eq("st_err",   {31'd0, bus_err}, 32'd0);
    check_eq("st_rdata", d_rdata, 32'h0);
    check_eq("st_wrt_off", {31'd0, mem_wrt}, 32'd0);
    d_req = 1'b0; d_wr = 1'b0; mem_ready = 1'b0;
    step();

    // Timeout: load never sees ready; ack with error at cycle 17.
    d_req = 1'b1; d_addr = 32'h80; mem_rdata = 32'h7777_7777;
    for (int c = 1; c <= 16; c++) step();
    check_eq("to_c16_busy", {31'd0, mem_read}, 32'd1);
    check_eq("to_c16_noack", {31'd0, d_ack}, 32'd0);
    step();
    check_eq("to_ack",   {31'd0, d_ack}, 32'd1);
    check_eq("to_err",   {31'd0, bus_err}, 32'd1);
    check_eq("to_rdata", d_rdata, 32'h0);
    check_eq("to_strobe_off", {31'd0, mem_read}, 32'd0);
    d_req = 1'b0;
    step();
    check_eq("to_err_clear", {31'd0, bus_err}, 32'd0);
    d_req = 1'b1; d_addr = 32'h84; mem_rdata = 32'h55AA_55AA;
    step();
    mem_ready = 1'b1;
    step();
    check_eq("post_to_ack",   {31'd0, d_ack}, 32'd1);
    check_eq("post_to_err",   {31'd0, bus_err}, 32'd0);
    check_eq("post_to_rdata", d_rdata, 32'h55AA_55AA);
    d_req = 1'b0; mem_ready = 1'b0;
    step();

    // Ready on the expiring cycle (16): success, no error.
    d_req = 1'b1; d_addr = 32'h88; mem_rdata = 32'h0BAD_F00D;
    for (int c = 1; c <= 16; c++) step();
    check_eq("tie_c16_busy", {31'd0, mem_read}, 32'd1);
    mem_ready = 1'b1;
    step();
    check_eq("tie_ack",   {31'd0, d_ack}, 32'd1);
    check_eq("tie_err",   {31'd0, bus_err}, 32'd0);
    check_eq("tie_rdata", d_rdata, 32'h0BAD_F00D);
    d_req = 1'b0; mem_ready = 1'b0;
    step();

    // Reset in cycle 2 of a fetch, then reissue with identical timing.
    if_req = 1'b1; if_addr = 32'h30; mem_rdata = 32'h1357_9BDF;
    step();
    check_eq("rb_mem_read", {31'd0, mem_read}, 32'd1);
    step();
    rst_n = 1'b0;
    #1;
    check_eq("rb_async_strobe", {30'd0, mem_read, mem_wrt}, 32'd0);
    check_eq("rb_async_ack",    {31'd0, if_ack}, 32'd0);
    step();
    check_eq("rb_no_ack", {31'd0, if_ack}, 32'd0);
    rst_n = 1'b1;
    step();
    check_eq("rb_reissue_read", {31'd0, mem_read}, 32'd1);
    check_eq("rb_reissue_addr", mem_addr, 32'h30);
    mem_ready = 1'b1;
    step();
    check_eq("rb_reissue_ack",   {31'd0, if_ack}, 32'd1);
    check_eq("rb_reissue_rdata", if_rdata, 32'h1357_9BDF);
    if_req = 1'b0; mem_ready = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
